// File: rtl/weighted_sum_pipelined_n.sv
// weighted_sum_pipelined_n: N_TAPS-lane unsigned dot product.
// Datapath: registered multiply, registered LOG2N-level adder tree, then a
// final stage that emits one sum per beat or accumulates beats until i_last.
// Flow control:
//   - i_valid/i_ready: a beat transfers on a rising edge when both are high.
//   - o_valid/o_ready: a result transfers on a rising edge when both are high.
//   - o_valid, once high, holds with o_data/o_sat stable until o_ready.
//   - i_ready is ~(o_valid & ~o_ready) and has no dependency on i_valid.
// Optional macro WSUM_SATURATE_EN: saturate o_data to all ones and raise
// o_sat when the sum does not fit in OUT_WIDTH bits. Without the macro,
// o_data is the truncated sum and o_sat stays 0.
module weighted_sum_pipelined_n #(
  parameter int WIDTH     = 16,
  parameter int N_TAPS    = 4,
  parameter int ACC_GUARD = 8,
  parameter int OUT_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_valid,
  output logic                       i_ready,
  input  logic                       i_mode,
  input  logic                       i_last,
  input  logic [N_TAPS*WIDTH-1:0]    i_data,
  input  logic [N_TAPS*WIDTH-1:0]    weights,
  output logic                       o_valid,
  input  logic                       o_ready,
  output logic [OUT_WIDTH-1:0]       o_data,
  output logic                       o_sat
);

  localparam int LOG2N = $clog2(N_TAPS);
  localparam int TREEW = 2*WIDTH + LOG2N;
  localparam int FULLW = TREEW + ACC_GUARD;

  // Stage 0 holds products; stage l (1..LOG2N) holds level-l pairwise sums.
  // All stages share the lossless tree width to keep the array regular.
  logic [TREEW-1:0] tree_q [0:LOG2N][0:N_TAPS-1];
  logic [TREEW-1:0] tree_d [0:LOG2N][0:N_TAPS-1];
  logic             vld_q  [0:LOG2N];
  logic             vld_d  [0:LOG2N];
  logic             mode_q [0:LOG2N];
  logic             mode_d [0:LOG2N];
  logic             last_q [0:LOG2N];
  logic             last_d [0:LOG2N];

  logic [FULLW-1:0]     acc_q, acc_d;
  logic                 acc_open_q, acc_open_d;
  logic                 o_valid_q, o_valid_d;
  logic [OUT_WIDTH-1:0] o_data_q, o_data_d;
  logic                 o_sat_q, o_sat_d;

  logic                 stall;
  logic                 accept;
  logic [FULLW-1:0]     sum;
  logic [OUT_WIDTH-1:0] res;
  logic                 sat;

  assign stall   = o_valid_q & ~o_ready;
  assign i_ready = ~stall;
  assign accept  = i_valid & i_ready;
  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;
  assign o_sat   = o_sat_q;

  // Multiply and tree stages advance together whenever the output is not stalled.
  always_comb begin
    tree_d = tree_q;
    vld_d  = vld_q;
    mode_d = mode_q;
    last_d = last_q;
    if (!stall) begin
      vld_d[0]  = accept;
      mode_d[0] = i_mode;
      last_d[0] = i_last;
      for (int k = 0; k < N_TAPS; k++) begin
        tree_d[0][k] = TREEW'(i_data[k*WIDTH +: WIDTH]) * TREEW'(weights[k*WIDTH +: WIDTH]);
      end
      for (int l = 1; l <= LOG2N; l++) begin
        vld_d[l]  = vld_q[l-1];
        mode_d[l] = mode_q[l-1];
        last_d[l] = last_q[l-1];
        for (int k = 0; k < N_TAPS/2; k++) begin
          if (k < (N_TAPS >> l)) begin
            tree_d[l][k] = tree_q[l-1][2*k] + tree_q[l-1][2*k+1];
          end
        end
      end
    end
  end

  // Output formatting: saturate or truncate the running sum.
  always_comb begin
    sum = (acc_open_q ? acc_q : '0) + FULLW'(tree_q[LOG2N][0]);
`ifdef WSUM_SATURATE_EN
    sat = |(sum >> OUT_WIDTH);
    res = sat ? '1 : sum[OUT_WIDTH-1:0];
`else
    sat = 1'b0;
    res = sum[OUT_WIDTH-1:0];
`endif
  end

  // Final stage: emit a result on per-beat or last beats, otherwise fold into acc.
  always_comb begin
    acc_d      = acc_q;
    acc_open_d = acc_open_q;
    o_valid_d  = o_valid_q;
    o_data_d   = o_data_q;
    o_sat_d    = o_sat_q;
    if (vld_q[LOG2N] && !stall) begin
      if (!mode_q[LOG2N] || last_q[LOG2N]) begin
        o_data_d   = res;
        o_sat_d    = sat;
        o_valid_d  = 1'b1;
        acc_d      = '0;
        acc_open_d = 1'b0;
      end else begin
        acc_d      = sum;
        acc_open_d = 1'b1;
        if (o_valid_q && o_ready) o_valid_d = 1'b0;
      end
    end else if (o_valid_q && o_ready) begin
      o_valid_d = 1'b0;
    end
  end

  // State registers; reset drops in-flight beats and any partial accumulation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int l = 0; l <= LOG2N; l++) begin
        vld_q[l]  <= 1'b0;
        mode_q[l] <= 1'b0;
        last_q[l] <= 1'b0;
        for (int k = 0; k < N_TAPS; k++) tree_q[l][k] <= '0;
      end
      acc_q      <= '0;
      acc_open_q <= 1'b0;
      o_valid_q  <= 1'b0;
      o_data_q   <= '0;
      o_sat_q    <= 1'b0;
    end else begin
      tree_q     <= tree_d;
      vld_q      <= vld_d;
      mode_q     <= mode_d;
      last_q     <= last_d;
      acc_q      <= acc_d;
      acc_open_q <= acc_open_d;
      o_valid_q  <= o_valid_d;
      o_data_q   <= o_data_d;
      o_sat_q    <= o_sat_d;
    end
  end

endmodule

// File: tb/tb_weighted_sum_pipelined_n.sv
// Bench for weighted_sum_pipelined_n with default parameters.
// Build with +define+WSUM_SATURATE_EN to check the saturating variant.
module tb_weighted_sum_pipelined_n;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        i_ready;
  logic        i_mode;
  logic        i_last;
  logic [63:0] i_data;
  logic [63:0] weights;
  logic        o_valid;
  logic        o_ready;
  logic [31:0] o_data;
  logic        o_sat;

  weighted_sum_pipelined_n dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_mode  (i_mode),
    .i_last  (i_last),
    .i_data  (i_data),
    .weights (weights),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_sat   (o_sat)
  );

  // Clock
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [63:0] wts;
    logic        mode;
    logic        last;
    logic        has_res;
    logic [32:0] exp;
  } vec_t;

  vec_t        vecs [12];
  logic [32:0] exp_q [$];
  int          total = 0;
  int          bad   = 0;

  function automatic logic [63:0] lanes(input logic [15:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic logic [63:0] rep(input logic [15:0] x);
    return {x, x, x, x};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  // Scoreboard: every accepted result must match the head of exp_q.
  always @(negedge clk) begin
    if (rst && o_valid && o_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_result got=%0h required=none", {o_sat, o_data});
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        if ({o_sat, o_data} !== e) begin
          bad++;
          $display("FAIL result got=%0h required=%0h", {o_sat, o_data}, e);
        end
      end
    end
  end

  // Driver: called at posedge+1, returns at posedge+1 just after acceptance.
  task automatic send(input vec_t v);
    bit ok;
    int n;
    i_valid = 1'b1;
    i_data  = v.data;
    weights = v.wts;
    i_mode  = v.mode;
    i_last  = v.last;
    if (v.has_res) exp_q.push_back(v.exp);
    n = 0;
    do begin
      ok = i_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 200);
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout got=stalled required=accept");
    end
  endtask

  task automatic idle();
    i_valid = 1'b0;
    i_mode  = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout got=%0d pending required=0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    // Stimulus table
    vecs[0]  = '{rep(16'd1), rep(16'd1), 1'b0, 1'b0, 1'b1, 33'd4};
    vecs[1]  = '{rep(16'd2), rep(16'd1), 1'b0, 1'b0, 1'b1, 33'd8};
    vecs[2]  = '{rep(16'd3), rep(16'd1), 1'b0, 1'b0, 1'b1, 33'd12};
    vecs[3]  = '{rep(16'd1), rep(16'd1000), 1'b1, 1'b0, 1'b0, 33'd0};
    vecs[4]  = '{rep(16'd1), rep(16'd1000), 1'b1, 1'b0, 1'b0, 33'd0};
    vecs[5]  = '{rep(16'd1), rep(16'd1000), 1'b1, 1'b1, 1'b1, 33'd12000};
    vecs[6]  = '{rep(16'hFFFF), rep(16'hFFFF), 1'b1, 1'b0, 1'b0, 33'd0};
`ifdef WSUM_SATURATE_EN
    vecs[7]  = '{rep(16'hFFFF), rep(16'hFFFF), 1'b1, 1'b1, 1'b1, {1'b1, 32'hFFFF_FFFF}};
`else
    vecs[7]  = '{rep(16'hFFFF), rep(16'hFFFF), 1'b1, 1'b1, 1'b1, {1'b0, 32'hFFF0_0008}};
`endif
    // Open accumulation of 4 closed by a per-beat 8, then a fresh 4 with last ignored.
    vecs[8]  = '{rep(16'd1), rep(16'd1), 1'b1, 1'b0, 1'b0, 33'd0};
    vecs[9]  = '{rep(16'd2), rep(16'd1), 1'b0, 1'b0, 1'b1, 33'd12};
    vecs[10] = '{rep(16'd1), rep(16'd1), 1'b0, 1'b1, 1'b1, 33'd4};
    vecs[11] = '{lanes(16'd1, 16'd2, 16'd3, 16'd4), lanes(16'd5, 16'd6, 16'd7, 16'd8),
                 1'b0, 1'b0, 1'b1, 33'd70};

    // Reset
    rst = 1'b0;
    o_ready = 1'b1;
    i_data = '0;
    weights = '0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("reset_o_valid", 64'(o_valid), 64'd0);
    check("reset_o_data", 64'(o_data), 64'd0);
    check("reset_o_sat", 64'(o_sat), 64'd0);
    check("reset_i_ready", 64'(i_ready), 64'd1);
    @(posedge clk);
    #1;

    // Single beat latency: o_valid high in exactly the 4th cycle after acceptance.
    send(vecs[11]);
    idle();
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check("t1_o_valid", 64'(o_valid), (i == 4) ? 64'd1 : 64'd0);
      if (i == 4) check("t1_o_data", 64'(o_data), 64'd70);
    end
    @(posedge clk);
    #1;

    // Three back-to-back beats produce three consecutive results.
    for (int i = 0; i < 3; i++) send(vecs[i]);
    idle();
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      check("t2_o_valid", 64'(o_valid), (j >= 2 && j <= 4) ? 64'd1 : 64'd0);
    end
    @(posedge clk);
    #1;
    drain();

    // Backpressure: first result held, pipe frozen, then released.
    o_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(vecs[i]);
    idle();
    begin
      int n;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!o_valid && n < 20);
      check("t3_valid_seen", 64'(o_valid), 64'd1);
    end
    for (int j = 0; j < 4; j++) begin
      check("t3_hold_data", 64'(o_data), 64'd4);
      check("t3_i_ready", 64'(i_ready), 64'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    o_ready = 1'b1;
    drain();
    check("t3_idle_after", 64'(o_valid), 64'd0);

    // Table of per-beat, accumulate, overflow and mode-switch beats, back to back.
    for (int i = 0; i < 12; i++) send(vecs[i]);
    idle();
    drain();

    // Reset in the middle of an accumulation.
    send(vecs[3]);
    send(vecs[4]);
    idle();
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6_rst_o_valid", 64'(o_valid), 64'd0);
    @(negedge clk);
    check("t6_rst_o_valid", 64'(o_valid), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("t6_i_ready", 64'(i_ready), 64'd1);
    check("t6_o_data", 64'(o_data), 64'd0);
    for (int j = 0; j < 6; j++) begin
      check("t6_quiet", 64'(o_valid), 64'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    send(vecs[11]);
    idle();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/weighted_sum_pipelined_n.md
Name: weighted_sum_pipelined_n

Overview:
Parametrised, handshaked successor to the fixed 4-tap weighted-sum pipeline. It computes the dot product of N_TAPS unsigned data/weight pairs through a registered multiply stage and a registered log2(N_TAPS)-level adder tree. A final accumulate stage either emits each beat's sum or accumulates beats until a last marker. It sits between a sample producer and a downstream consumer, with valid/ready flow control on both sides.

Parameters:
WIDTH, 16, bit width of each data and weight lane (unsigned).
N_TAPS, 4, number of lanes; power of two, >= 2.
ACC_GUARD, 8, extra accumulator bits above the tree width.
OUT_WIDTH, 32, width of o_data; must be <= FULLW.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
i_valid  in  1  input beat valid.
i_ready  out  1  block can accept a beat.
i_mode  in  1  0 = per-beat sum, 1 = accumulate until i_last.
i_last  in  1  final beat of an accumulation (ignored when i_mode=0).
i_data  in  N_TAPS*WIDTH  lane k at [k*WIDTH +: WIDTH].
weights  in  N_TAPS*WIDTH  lane k at [k*WIDTH +: WIDTH].
o_valid  out  1  result valid.
o_ready  in  1  consumer accepts result.
o_data  out  OUT_WIDTH  result.
o_sat  out  1  result was saturated (see Optional Feature).

Behaviour:
- Widths: LOG2N = $clog2(N_TAPS). Products are 2*WIDTH bits. The tree is 2*WIDTH+LOG2N bits and is lossless. FULLW = 2*WIDTH+LOG2N+ACC_GUARD. The accumulator wraps modulo 2^FULLW.
- Stages:
  - S1 registers the N products.
  - Tree levels 1..LOG2N each register pairwise sums.
  - The final stage registers o_data, o_valid and o_sat.
  - Latency from an accepted beat to o_valid is LOG2N+2 cycles; 4 for the defaults.
- Sideband: i_mode and i_last travel alongside the data with a valid bit in every stage.
- Flow control:
  - stall = o_valid & ~o_ready.
  - i_ready = ~stall (combinational).
  - A beat is accepted when i_valid & i_ready.
  - All pipeline registers and valid bits hold during a stall.
  - Bubbles (invalid stages) propagate and never produce output.
- Final stage, when the tree-output valid arrives and there is no stall:
  - sum = (acc_open ? acc : 0) + tree.
  - If mode=0, or mode=1 with last=1: load o_data from sum (see Optional Feature), set o_valid=1, clear acc and acc_open.
  - If mode=1 with last=0: acc<=sum, acc_open<=1, and o_valid is cleared if it was being consumed.
  - When no tree beat arrives and o_valid&o_ready: o_valid<=0.
  - A mode=0 beat arriving while acc_open=1 completes the open accumulation. The next beat is then a fresh start (no silent discard).
- Ordering: results appear strictly in acceptance order. Back-to-back throughput is one beat per cycle with o_ready held high.
- Reset: all valid bits, acc and acc_open clear to 0; o_data=0, o_valid=0, o_sat=0; i_ready=1 after reset. Reset mid-accumulation discards the partial sum and any in-flight beats.

Optional Feature:
Macro WSUM_SATURATE_EN.
- Defined: if any bit of sum at index >= OUT_WIDTH is 1, o_data is all ones and o_sat=1. Otherwise o_data = sum[OUT_WIDTH-1:0] and o_sat=0.
- Undefined: o_data = sum[OUT_WIDTH-1:0] (truncating wrap) and o_sat is tied 0.
- The internal accumulator wraps at FULLW in both cases.

Test Plan:
All cases use the defaults: N_TAPS=4, WIDTH=16, OUT_WIDTH=32, ACC_GUARD=8.
1. Release reset, then one mode=0 beat: data {1,2,3,4}, weights {5,6,7,8}, o_ready=1 -> o_valid rises 4 cycles after acceptance, o_data=70, for exactly one cycle.
2. Three back-to-back mode=0 beats (all weights=1; data all 1, all 2, all 3) -> three consecutive o_valid cycles with o_data 4, 8, 12 in order.
3. Same stream with o_ready=0 while the first result is valid -> i_ready=0, o_data holds at 4 and the pipe freezes. Raise o_ready -> 8 and 12 follow with no loss or duplication.
4. Accumulate: three mode=1 beats (data all 1, weights all 1000), last on the third -> no o_valid on beats 1-2, then a single o_data=12000.
5. Overflow: two mode=1 beats with all lanes 0xFFFF for data and weights, last on the second -> internal sum 0x7FFF00008. Without the macro: o_data=0xFFF00008, o_sat=0. With WSUM_SATURATE_EN: o_data=0xFFFFFFFF, o_sat=1.
6. Two mode=1 beats (no last), assert rst for 2 cycles, then the mode=0 beat {1,2,3,4}·{5,6,7,8} -> o_valid stays low during and after reset until a single o_data=70 (no stale partial sum).
